mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multicycle control unit for the RISC-V core: a Moore FSM plus combinational instruction, ALU and immediate-select decoders. It sequences fetch, decode, execute, memory and writeback for each instruction. It drives the immediate extender's 2-bit select and the datapath muxes and enables. It stalls on the cache handshake for every memory access.

## Interface
Parameters: none; all encodings are fixed in the package.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  7  instruction[6:0], from the instruction register
- funct3  in  3  instruction[14:12]
- funct7b5  in  1  instruction[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  cache has completed the current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  store; valid only while mem_req=1
- adr_src  out  1  0: PC; 1: Result
- ir_write  out  1  instruction register enable
- pc_write  out  1  PC enable
- reg_write  out  1  register file write enable
- result_src  out  2  00: ALUOut; 01: Data; 10: ALUResult
- alu_src_a  out  2  00: PC; 01: OldPC; 10: RD1
- alu_src_b  out  2  00: RD2; 01: ImmExt; 10: constant 4
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src  out  2  00 I, 01 S, 10 B, 11 J
- illegal  out  1  one-cycle pulse in DECODE when the opcode is unsupported

## Operation
- Supported opcodes:
  - lw 0000011, sw 0100011, R 0110011, I-ALU 0010011: next state MEMADR, MEMADR, EXECUTER, EXECUTEI.
  - branch 1100011: beq when funct3=000, bne when funct3=001. Next state BRANCH.
  - jal 1101111: next state JAL.
  - Any other opcode: raise `illegal` and return to FETCH. No write enables assert.
- State outputs. Any output not listed is 0.
  - FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10. ir_write=pc_write=mem_ready.
  - DECODE: alu_src_a=01, alu_src_b=01, add. This precomputes the branch target.
  - MEMADR: alu_src_a=10, alu_src_b=01, add. Next state is MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: mem_req=1, adr_src=1, result_src=00. Advances to MEMWB on mem_ready.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00. Advances to FETCH on mem_ready.
  - EXECUTER: alu_src_a=10, alu_src_b=00, ALU decode.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, ALU decode.
  - ALUWB: result_src=00, reg_write=1.
  - JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1. Next state ALUWB.
  - BRANCH: alu_src_a=10, alu_src_b=00, sub, result_src=00. pc_write=zero XOR funct3[0].
- Transitions:
  - EXECUTER and EXECUTEI go to ALUWB.
  - MEMWB, ALUWB and BRANCH go to FETCH.
  - FETCH holds until mem_ready, then goes to DECODE.
- ALU decode:
  - funct3=000: sub if op[5]&funct7b5, else add.
  - funct3=010: slt.
  - funct3=110: or.
  - funct3=111: and.
  - Any other funct3: add.
- imm_src is combinational from op in every state: sw→01, branch→10, jal→11, all others→00.

## Timing
- Reset: state=FETCH. With mem_ready=0, all outputs are 0 except mem_req=1, alu_src_b=10, result_src=10.
- Reset mid-access drops to FETCH immediately. Any mem_req in flight is abandoned; the cache must tolerate this.
- Minimum latencies with mem_ready=1 on the first request cycle:
  - lw: 5 cycles.
  - sw: 4 cycles.
  - R-type and I-ALU: 4 cycles.
  - jal: 4 cycles.
  - branch: 3 cycles.
  - Illegal opcode: 2 cycles.
- Each wait cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- While waiting, every output holds its value and no enable pulses.
- mem_ready outside a requesting state is ignored.
- pc_write and ir_write in FETCH assert only in the mem_ready cycle, exactly once per instruction.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - state enum;
  - opcode localparams;
  - ALUOp (00 add, 01 sub, 10 funct);
  - ALU control codes;
  - mux select codes;
  - ImmSrc codes (shared with the immediate extender).
- One sub-module, `alu_decoder`, maps ALUOp, funct3, op[5] and funct7b5 to alu_control. The FSM and imm_src decode stay in the top module.

## Test plan
- Reset asserted mid-MEMREAD: state returns to FETCH asynchronously and outputs take their reset values. After release, the first fetch shows mem_req=1, adr_src=0.
- lw (op 0000011), mem_ready held at 1: state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. imm_src=00; reg_write=1 only in cycle 5.
- sw with mem_ready low for 3 cycles in MEMWRITE: mem_write=mem_req=1 for 4 cycles, then FETCH. reg_write is never asserted.
- beq with zero=1 gives pc_write=1 in BRANCH; bne (funct3=001) with zero=1 gives pc_write=0. imm_src=10 in both cases.
- R-type sub (funct3=000, funct7b5=1) gives alu_control=001; addi with funct7b5=1 gives 000; funct3=111 gives 010.
- op=1111111: illegal=1 for one cycle in DECODE, then FETCH; reg_write, mem_write and pc_write all stay 0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit and its datapath.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_RESULT = 1'b1;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Immediate formats, shared with the immediate extender.
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALUOp plus instruction fields to an ALU operation code.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       op_b5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    // Fixed add/sub for address and compare work, funct3-driven otherwise;
    // sub needs op[5] so that addi with imm[10]=1 stays an add.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op_b5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V control unit: Moore sequencing FSM, ALU and immediate decode.
module mc_control_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] imm_src,
    output logic       illegal
);

    state_t  state_q, state_d;
    alu_op_t alu_op;

    // State register; reset abandons any access in flight and restarts at fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next state and per-state datapath controls; memory states hold until mem_ready.
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = ADR_PC;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALUOP_ADD;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // OldPC + imm precomputes the branch target into ALUOut.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_ITYPE:     state_d = S_EXECUTEI;
                    OP_BRANCH:    state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = ADR_RESULT;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = ADR_RESULT;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_RD2;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while PC+4 is formed for rd.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BRANCH: begin
                // funct3[0] distinguishes bne from beq by inverting the taken sense.
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_RD2;
                alu_op    = ALUOP_SUB;
                pc_write  = zero ^ funct3[0];
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        case (op)
            OP_SW:     imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op_b5       (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-cycle comparison against a phase-level model.
module tb_mc_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;

    // Output bundle: [17] mem_req [16] mem_write [15] adr_src [14] ir_write
    // [13] pc_write [12] reg_write [11:10] result_src [9:8] alu_src_a
    // [7:6] alu_src_b [5:3] alu_control [2:1] imm_src [0] illegal
    logic [17:0] dut_vec;
    assign dut_vec = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                      result_src, alu_src_a, alu_src_b, alu_control, imm_src, illegal};

    localparam logic [17:0] RESET_VEC = 18'h20880;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                  P_EXECUTER, P_EXECUTEI, P_ALUWB, P_JAL, P_BRANCH} phase_t;

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .imm_src(imm_src),
        .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit supported(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
    endfunction

    function automatic logic [1:0] imm_for(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    // ALU operation implied by the instruction's arithmetic meaning.
    function automatic logic [2:0] alu_for(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        if (f3 == 3'd0) return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
        if (f3 == 3'd2) return 3'b101;
        if (f3 == 3'd6) return 3'b011;
        if (f3 == 3'd7) return 3'b010;
        return 3'b000;
    endfunction

    // Phases an instruction passes through, in order.
    function automatic int n_phases(input logic [6:0] o);
        if (!supported(o))    return 2;
        if (o == 7'b0000011)  return 5;
        if (o == 7'b1100011)  return 3;
        return 4;
    endfunction

    function automatic phase_t phase_at(input logic [6:0] o, input int i);
        if (i == 0) return P_FETCH;
        if (i == 1) return P_DECODE;
        case (o)
            7'b0000011: return (i == 2) ? P_MEMADR : (i == 3) ? P_MEMREAD : P_MEMWB;
            7'b0100011: return (i == 2) ? P_MEMADR : P_MEMWRITE;
            7'b0110011: return (i == 2) ? P_EXECUTER : P_ALUWB;
            7'b0010011: return (i == 2) ? P_EXECUTEI : P_ALUWB;
            7'b1101111: return (i == 2) ? P_JAL : P_ALUWB;
            default:    return P_BRANCH;
        endcase
    endfunction

    // Expected output bundle for a phase given the current inputs.
    function automatic logic [17:0] exp_out(input phase_t p, input logic [6:0] o,
                                            input logic [2:0] f3, input logic f7,
                                            input logic zr, input logic mr);
        logic mreq, mwr, adr, irw, pcw, rgw, ill;
        logic [1:0] rs, sa, sb;
        logic [2:0] ac;
        {mreq, mwr, adr, irw, pcw, rgw, ill} = '0;
        rs = 2'b00; sa = 2'b00; sb = 2'b00; ac = 3'b000;
        case (p)
            P_FETCH:    begin mreq = 1; sb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
            P_DECODE:   begin sa = 2'b01; sb = 2'b01; ill = !supported(o); end
            P_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            P_MEMREAD:  begin mreq = 1; adr = 1; end
            P_MEMWB:    begin rs = 2'b01; rgw = 1; end
            P_MEMWRITE: begin mreq = 1; mwr = 1; adr = 1; end
            P_EXECUTER: begin sa = 2'b10; ac = alu_for(o, f3, f7); end
            P_EXECUTEI: begin sa = 2'b10; sb = 2'b01; ac = alu_for(o, f3, f7); end
            P_ALUWB:    rgw = 1;
            P_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            P_BRANCH:   begin sa = 2'b10; ac = 3'b001; pcw = zr ^ f3[0]; end
            default:    ;
        endcase
        return {mreq, mwr, adr, irw, pcw, rgw, rs, sa, sb, ac, imm_for(o), ill};
    endfunction

    task automatic check(input string nm, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, want);
        end
    endtask

    // One clock cycle in phase p: drive inputs, compare at the falling edge.
    task automatic step(input phase_t p, input logic mr, input logic zr, output logic [17:0] sv);
        logic [17:0] want;
        mem_ready = mr;
        zero      = zr;
        want      = exp_out(p, op, funct3, funct7b5, zr, mr);
        @(negedge clk);
        sv = dut_vec;
        check($sformatf("%s_outputs", p.name()), int'(dut_vec), int'(want));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Run one instruction; fw/mw are wait cycles in fetch and in the data access.
    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic zr, input int fw, input int mw,
                             input int want_cyc, input phase_t probe, output logic [17:0] pv);
        logic [17:0] sv;
        phase_t      p;
        int          waits;
        logic        req;
        op = o; funct3 = f3; funct7b5 = f7;
        cyc = 0;
        pv  = '0;
        for (int i = 0; i < n_phases(o); i++) begin
            p     = phase_at(o, i);
            req   = (p == P_FETCH || p == P_MEMREAD || p == P_MEMWRITE);
            waits = (p == P_FETCH) ? fw : (req ? mw : 0);
            for (int w = 0; w <= waits; w++) begin
                step(p, req ? (w == waits) : 1'($urandom_range(0, 1)),
                     (p == P_BRANCH) ? zr : 1'($urandom_range(0, 1)), sv);
                if (p == probe) pv = sv;
            end
        end
        check({name, "_latency"}, cyc, want_cyc);
    endtask

    initial begin
        logic [17:0] pv;
        logic [17:0] sv;
        rst_n = 1'b1; op = 7'b0000011; funct3 = 3'd0; funct7b5 = 1'b0;
        zero = 1'b0; mem_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1 check("reset_outputs", int'(dut_vec), int'(RESET_VEC));
        repeat (2) @(posedge clk);
        #1 check("reset_hold_outputs", int'(dut_vec), int'(RESET_VEC));
        rst_n = 1'b1;

        run_instr("lw", 7'b0000011, 3'd2, 1'b0, 1'b0, 0, 0, 5, P_MEMWB, pv);
        check("lw_memwb_reg_write", int'(pv[12]), 1);
        check("lw_imm_src", int'(pv[2:1]), 0);

        run_instr("sw_wait", 7'b0100011, 3'd2, 1'b0, 1'b0, 1, 3, 8, P_MEMWRITE, pv);
        check("sw_mem_write", int'(pv[17:16]), 3);
        check("sw_imm_src", int'(pv[2:1]), 1);

        run_instr("beq_taken", 7'b1100011, 3'd0, 1'b0, 1'b1, 0, 0, 3, P_BRANCH, pv);
        check("beq_pc_write", int'(pv[13]), 1);
        check("beq_imm_src", int'(pv[2:1]), 2);

        run_instr("bne_zero", 7'b1100011, 3'd1, 1'b0, 1'b1, 0, 0, 3, P_BRANCH, pv);
        check("bne_pc_write", int'(pv[13]), 0);
        check("bne_imm_src", int'(pv[2:1]), 2);

        run_instr("beq_not_taken", 7'b1100011, 3'd0, 1'b0, 1'b0, 2, 0, 5, P_BRANCH, pv);
        check("beq_nt_pc_write", int'(pv[13]), 0);

        run_instr("r_sub", 7'b0110011, 3'd0, 1'b1, 1'b0, 0, 0, 4, P_EXECUTER, pv);
        check("r_sub_alu", int'(pv[5:3]), 1);

        run_instr("addi_f7", 7'b0010011, 3'd0, 1'b1, 1'b0, 0, 0, 4, P_EXECUTEI, pv);
        check("addi_alu", int'(pv[5:3]), 0);

        run_instr("r_and", 7'b0110011, 3'd7, 1'b0, 1'b0, 0, 0, 4, P_EXECUTER, pv);
        check("r_and_alu", int'(pv[5:3]), 2);

        run_instr("ori", 7'b0010011, 3'd6, 1'b0, 1'b0, 0, 0, 4, P_EXECUTEI, pv);
        check("ori_alu", int'(pv[5:3]), 3);

        run_instr("r_slt", 7'b0110011, 3'd2, 1'b1, 1'b0, 0, 0, 4, P_EXECUTER, pv);
        check("r_slt_alu", int'(pv[5:3]), 5);

        run_instr("jal", 7'b1101111, 3'd0, 1'b0, 1'b0, 0, 0, 4, P_JAL, pv);
        check("jal_pc_write", int'(pv[13]), 1);
        check("jal_imm_src", int'(pv[2:1]), 3);

        run_instr("illegal", 7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0, 2, P_DECODE, pv);
        check("illegal_pulse", int'(pv[0]), 1);
        check("illegal_no_enables", int'({pv[16], pv[13:12]}), 0);

        run_instr("lw_wait", 7'b0000011, 3'd2, 1'b0, 1'b0, 2, 2, 9, P_MEMREAD, pv);
        check("lw_memread_req", int'(pv[17:15]), 5);

        // Reset asserted while a load is waiting on the cache.
        op = 7'b0000011; funct3 = 3'd2; funct7b5 = 1'b0;
        step(P_FETCH, 1'b1, 1'b0, sv);
        step(P_DECODE, 1'b0, 1'b0, sv);
        step(P_MEMADR, 1'b1, 1'b0, sv);
        mem_ready = 1'b0;
        #2;
        check("memread_pre_reset", int'({mem_req, adr_src}), 3);
        rst_n = 1'b0;
        #1 check("reset_mid_memread", int'(dut_vec), int'(RESET_VEC));
        @(posedge clk);
        #1 check("reset_mid_memread_hold", int'(dut_vec), int'(RESET_VEC));
        rst_n = 1'b1;
        run_instr("lw_after_reset", 7'b0000011, 3'd2, 1'b0, 1'b0, 0, 0, 5, P_FETCH, pv);
        check("first_fetch_req_adr", int'({pv[17], pv[15]}), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
